// File: rtl/sum_offset_calibrator_pkg.sv
// Shared state encoding and arithmetic helpers for the SUM offset calibrator.
// Also used by the offset/scale datapath adders for saturation.
package sum_offset_calibrator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    COMPUTE,
    APPLY,
    SETTLE
  } cal_state_t;

  // Accumulator width that cannot overflow for 2^log2_n samples of in_w bits.
  function automatic int unsigned acc_w(input int unsigned in_w, input int unsigned log2_n);
    return in_w + log2_n;
  endfunction

  // Clamp a sign-extended value to the signed range of the given width.
  function automatic longint sat_signed(input longint value, input int unsigned width);
    longint max_v;
    longint min_v;
    max_v = (longint'(1) <<< (width - 1)) - 1;
    min_v = -(longint'(1) <<< (width - 1));
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

endpackage

// File: rtl/sum_offset_calibrator_if.sv
// Host- and datapath-facing signals of the SUM offset calibrator.
// The master side is the host; the calibrator connects to the slave side.
interface sum_offset_calibrator_if #(
  parameter int unsigned INPUT_BIT_SIZE = 16,
  parameter int unsigned COEFF_BIT_SIZE = 10
);
  logic signed [INPUT_BIT_SIZE-1:0] SUM;
  logic                             sum_valid;
  logic                             cal_start;
  logic                             cal_abort;
  logic signed [INPUT_BIT_SIZE-1:0] z_trim;
  logic        [COEFF_BIT_SIZE-1:0] staged_div_multiplier;
  logic        [COEFF_BIT_SIZE-1:0] staged_z_multiplier;
  logic                             commit;

  logic signed [INPUT_BIT_SIZE-1:0] div_offset;
  logic signed [INPUT_BIT_SIZE-1:0] z_offset;
  logic        [COEFF_BIT_SIZE-1:0] div_multiplier;
  logic        [COEFF_BIT_SIZE-1:0] z_multiplier;
  logic signed [INPUT_BIT_SIZE-1:0] cal_mean;
  logic                             busy;
  logic                             done;
  logic                             aborted;
  logic                             saturated;

  modport master (
    output SUM, sum_valid, cal_start, cal_abort, z_trim,
           staged_div_multiplier, staged_z_multiplier, commit,
    input  div_offset, z_offset, div_multiplier, z_multiplier,
           cal_mean, busy, done, aborted, saturated
  );

  modport slave (
    input  SUM, sum_valid, cal_start, cal_abort, z_trim,
           staged_div_multiplier, staged_z_multiplier, commit,
    output div_offset, z_offset, div_multiplier, z_multiplier,
           cal_mean, busy, done, aborted, saturated
  );
endinterface

// File: rtl/sum_offset_calibrator_sample_averager.sv
// Accumulates 2^LOG2_SAMPLES signed SUM samples and tracks the gap since the
// last sample; mean is the floor of the accumulated average.
module sum_offset_calibrator_sample_averager
  import sum_offset_calibrator_pkg::*;
#(
  parameter int unsigned INPUT_BIT_SIZE = 16,
  parameter int unsigned LOG2_SAMPLES   = 10,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             valid,
  input  logic signed [INPUT_BIT_SIZE-1:0] SUM,
  output logic                             full,
  output logic                             timeout,
  output logic signed [INPUT_BIT_SIZE-1:0] mean
);
  localparam int unsigned ACC_W = acc_w(INPUT_BIT_SIZE, LOG2_SAMPLES);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [LOG2_SAMPLES:0] CNT_ONE  = (LOG2_SAMPLES + 1)'(1);
  localparam logic [TO_W-1:0]       TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0]       TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic signed [ACC_W-1:0]  acc;
  logic [LOG2_SAMPLES:0]    count;
  logic [TO_W-1:0]          quiet_cycles;
  logic                     accept;

  assign accept = valid && !full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc          <= '0;
      count        <= '0;
      quiet_cycles <= '0;
    end else if (clear) begin
      acc          <= '0;
      count        <= '0;
      quiet_cycles <= '0;
    end else begin
      if (accept) begin
        acc   <= acc + {{LOG2_SAMPLES{SUM[INPUT_BIT_SIZE-1]}}, SUM};
        count <= count + CNT_ONE;
      end
      if (valid) begin
        quiet_cycles <= '0;
      end else if (!timeout) begin
        quiet_cycles <= quiet_cycles + TO_ONE;
      end
    end
  end

  assign full    = count[LOG2_SAMPLES];
  assign timeout = (quiet_cycles == TO_LIMIT);
  // Taking the upper bits is the arithmetic shift right by LOG2_SAMPLES (floor).
  assign mean    = acc[ACC_W-1:LOG2_SAMPLES];

endmodule

// File: rtl/sum_offset_calibrator.sv
// Calibration FSM and coefficient registers for the SUM offset/scale datapath:
// nulls SUM by averaging samples and applies host multipliers atomically with the offsets.
module sum_offset_calibrator
  import sum_offset_calibrator_pkg::*;
#(
  parameter int unsigned INPUT_BIT_SIZE     = 16,
  parameter int unsigned COEFF_BIT_SIZE     = 10,
  parameter int unsigned LOG2_SAMPLES       = 10,
  parameter int unsigned SETTLE_CYCLES      = 4,
  parameter int unsigned TIMEOUT_CYCLES     = 65535,
  parameter int unsigned DEFAULT_MULTIPLIER = 128
) (
  input logic                   clk,
  input logic                   reset,
  sum_offset_calibrator_if.slave bus
);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [COEFF_BIT_SIZE-1:0] DEF_MULT = COEFF_BIT_SIZE'(DEFAULT_MULTIPLIER);
  localparam logic [SET_W-1:0]          SET_ONE  = SET_W'(1);
  localparam logic [SET_W-1:0]          SET_LAST = SET_W'(SETTLE_CYCLES);

  cal_state_t state;
  cal_state_t state_next;
  logic [SET_W-1:0] settle_cnt;

  logic clear_avg;
  logic do_compute;
  logic do_apply;
  logic finish_ok;
  logic finish_abort;

  logic                             avg_valid;
  logic                             avg_full;
  logic                             avg_timeout;
  logic signed [INPUT_BIT_SIZE-1:0] avg_mean;

  logic signed [INPUT_BIT_SIZE:0]   d_full;
  logic signed [INPUT_BIT_SIZE+1:0] zo_full;
  longint                           d_wide;
  longint                           zo_wide;
  logic signed [INPUT_BIT_SIZE-1:0] d_sat;
  logic signed [INPUT_BIT_SIZE-1:0] zo_sat;
  logic                             d_clip;
  logic                             zo_clip;

  logic signed [INPUT_BIT_SIZE-1:0] d_reg;
  logic signed [INPUT_BIT_SIZE-1:0] zo_reg;
  logic                             commit_pending;
  logic        [COEFF_BIT_SIZE-1:0] pend_div;
  logic        [COEFF_BIT_SIZE-1:0] pend_z;

  // Abort wins over a coincident sample, including the final one.
  assign avg_valid = bus.sum_valid && (state == ACCUM) && !bus.cal_abort;

  sum_offset_calibrator_sample_averager #(
    .INPUT_BIT_SIZE (INPUT_BIT_SIZE),
    .LOG2_SAMPLES   (LOG2_SAMPLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_sample_averager (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_avg),
    .valid   (avg_valid),
    .SUM     (bus.SUM),
    .full    (avg_full),
    .timeout (avg_timeout),
    .mean    (avg_mean)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == SETTLE) settle_cnt <= settle_cnt + SET_ONE;
      else                 settle_cnt <= '0;
    end
  end

  always_comb begin
    state_next   = state;
    clear_avg    = 1'b0;
    do_compute   = 1'b0;
    do_apply     = 1'b0;
    finish_ok    = 1'b0;
    finish_abort = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cal_start) begin
          state_next = ACCUM;
          clear_avg  = 1'b1;
        end
      end
      ACCUM: begin
        if (bus.cal_abort || avg_timeout) begin
          state_next   = IDLE;
          finish_abort = 1'b1;
        end else if (avg_full) begin
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        if (bus.cal_abort) begin
          state_next   = IDLE;
          finish_abort = 1'b1;
        end else begin
          state_next = APPLY;
          do_compute = 1'b1;
        end
      end
      APPLY: begin
        do_apply = 1'b1;
        if (bus.cal_abort) begin
          state_next   = IDLE;
          finish_abort = 1'b1;
        end else begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (bus.cal_abort) begin
          state_next   = IDLE;
          finish_abort = 1'b1;
        end else if (settle_cnt == SET_LAST) begin
          state_next = IDLE;
          finish_ok  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // z offset is formed from the unclamped negated mean so the trim sees full precision.
  always_comb begin
    d_full  = -{avg_mean[INPUT_BIT_SIZE-1], avg_mean};
    zo_full = {d_full[INPUT_BIT_SIZE], d_full}
            + {{2{bus.z_trim[INPUT_BIT_SIZE-1]}}, bus.z_trim};
    d_wide  = sat_signed(longint'(d_full), INPUT_BIT_SIZE);
    zo_wide = sat_signed(longint'(zo_full), INPUT_BIT_SIZE);
    d_clip  = (d_wide != longint'(d_full));
    zo_clip = (zo_wide != longint'(zo_full));
    d_sat   = d_wide[INPUT_BIT_SIZE-1:0];
    zo_sat  = zo_wide[INPUT_BIT_SIZE-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.div_offset     <= '0;
      bus.z_offset       <= '0;
      bus.div_multiplier <= DEF_MULT;
      bus.z_multiplier   <= DEF_MULT;
      bus.cal_mean       <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.aborted        <= 1'b0;
      bus.saturated      <= 1'b0;
      d_reg              <= '0;
      zo_reg             <= '0;
      commit_pending     <= 1'b0;
      pend_div           <= '0;
      pend_z             <= '0;
    end else begin
      bus.busy    <= (state_next != IDLE);
      bus.done    <= finish_ok;
      bus.aborted <= finish_abort;

      if (clear_avg) begin
        bus.saturated <= 1'b0;
      end else if (do_compute && (d_clip || zo_clip)) begin
        bus.saturated <= 1'b1;
      end

      if (do_compute) begin
        bus.cal_mean <= avg_mean;
        d_reg        <= d_sat;
        zo_reg       <= zo_sat;
      end

      if (do_apply) begin
        bus.div_offset <= d_reg;
        bus.z_offset   <= zo_reg;
      end

      // A commit landing in the APPLY cycle itself is the newest one and wins.
      if (do_apply && (bus.commit || commit_pending)) begin
        bus.div_multiplier <= bus.commit ? bus.staged_div_multiplier : pend_div;
        bus.z_multiplier   <= bus.commit ? bus.staged_z_multiplier : pend_z;
        commit_pending     <= 1'b0;
      end else if (finish_abort) begin
        commit_pending <= 1'b0;
      end else if (bus.commit) begin
        if (state == IDLE) begin
          bus.div_multiplier <= bus.staged_div_multiplier;
          bus.z_multiplier   <= bus.staged_z_multiplier;
          commit_pending     <= 1'b0;
        end else begin
          commit_pending <= 1'b1;
          pend_div       <= bus.staged_div_multiplier;
          pend_z         <= bus.staged_z_multiplier;
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_offset_calibrator.sv
// Directed bench for sum_offset_calibrator with 16-sample calibrations and a short timeout.
module tb_sum_offset_calibrator;
  localparam int unsigned IW     = 16;
  localparam int unsigned CW     = 10;
  localparam int unsigned L2     = 4;
  localparam int unsigned NS     = 16;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned TMO    = 40;
  localparam int unsigned DEFM   = 128;

  logic clk = 1'b0;
  logic reset;
  int vectors = 0;
  int miscompares = 0;

  sum_offset_calibrator_if #(.INPUT_BIT_SIZE(IW), .COEFF_BIT_SIZE(CW)) bus ();

  sum_offset_calibrator #(
    .INPUT_BIT_SIZE     (IW),
    .COEFF_BIT_SIZE     (CW),
    .LOG2_SAMPLES       (L2),
    .SETTLE_CYCLES      (SETTLE),
    .TIMEOUT_CYCLES     (TMO),
    .DEFAULT_MULTIPLIER (DEFM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cal();
    bus.cal_start = 1'b1;
    tick();
    bus.cal_start = 1'b0;
  endtask

  // One valid sample every third cycle.
  task automatic feed(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bus.SUM = v;
      bus.sum_valid = 1'b1;
      tick();
      bus.sum_valid = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic do_commit(input logic [9:0] dm, input logic [9:0] zm);
    bus.staged_div_multiplier = dm;
    bus.staged_z_multiplier = zm;
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (bus.done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({bus.div_offset, bus.z_offset, bus.cal_mean} !== 48'h0) begin
      miscompares++;
      $display("FAIL reset_offsets_mean: got %h want %h", {bus.div_offset, bus.z_offset, bus.cal_mean}, 48'h0);
    end
    vectors++;
    if ({bus.div_multiplier, bus.z_multiplier} !== {10'd128, 10'd128}) begin
      miscompares++;
      $display("FAIL reset_multipliers: got %0d/%0d want 128/128", bus.div_multiplier, bus.z_multiplier);
    end
    vectors++;
    if ({bus.busy, bus.done, bus.aborted, bus.saturated} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.aborted, bus.saturated});
    end
  endtask

  task automatic test_basic();
    int apply_at = -1;
    int done_at = -1;
    logic done_busy = 1'b1;
    bus.z_trim = 16'h0000;
    start_cal();
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy: got %b want 1", bus.busy);
    end
    feed(16'h0100, NS);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (apply_at < 0 && bus.div_offset === 16'hFF00) apply_at = i;
      if (bus.done === 1'b1) begin
        done_at = i;
        done_busy = bus.busy;
        break;
      end
    end
    vectors++;
    if (apply_at < 0 || done_at < 0 || (done_at - apply_at) != SETTLE + 1) begin
      miscompares++;
      $display("FAIL basic_done_latency: got apply=%0d done=%0d want gap %0d", apply_at, done_at, SETTLE + 1);
    end
    vectors++;
    if ({bus.div_offset, bus.z_offset} !== {16'hFF00, 16'hFF00}) begin
      miscompares++;
      $display("FAIL basic_offsets: got %h/%h want ff00/ff00", bus.div_offset, bus.z_offset);
    end
    vectors++;
    if (bus.cal_mean !== 16'h0100) begin
      miscompares++;
      $display("FAIL basic_cal_mean: got %h want 0100", bus.cal_mean);
    end
    vectors++;
    if ({done_busy, bus.saturated} !== 2'b00) begin
      miscompares++;
      $display("FAIL basic_busy_sat_at_done: got %b want 00", {done_busy, bus.saturated});
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_pulse: got %b want 0", bus.done);
    end
  endtask

  task automatic test_idle_commit();
    bus.staged_div_multiplier = 10'd200;
    bus.staged_z_multiplier = 10'd300;
    vectors++;
    if ({bus.div_multiplier, bus.z_multiplier} !== {10'd128, 10'd128}) begin
      miscompares++;
      $display("FAIL idle_commit_before: got %0d/%0d want 128/128", bus.div_multiplier, bus.z_multiplier);
    end
    do_commit(10'd200, 10'd300);
    vectors++;
    if ({bus.div_multiplier, bus.z_multiplier} !== {10'd200, 10'd300}) begin
      miscompares++;
      $display("FAIL idle_commit_mult: got %0d/%0d want 200/300", bus.div_multiplier, bus.z_multiplier);
    end
    vectors++;
    if ({bus.div_offset, bus.z_offset, bus.busy} !== {16'hFF00, 16'hFF00, 1'b0}) begin
      miscompares++;
      $display("FAIL idle_commit_offsets: got %h/%h busy %b want ff00/ff00 busy 0", bus.div_offset, bus.z_offset, bus.busy);
    end
    do_commit(10'd128, 10'd128);
    vectors++;
    if ({bus.div_multiplier, bus.z_multiplier} !== {10'd128, 10'd128}) begin
      miscompares++;
      $display("FAIL idle_commit_restore: got %0d/%0d want 128/128", bus.div_multiplier, bus.z_multiplier);
    end
  endtask

  task automatic test_saturation();
    bit got;
    start_cal();
    feed(16'h8000, NS);
    wait_done(20, got);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL sat_pos_done: got no done want done");
    end
    vectors++;
    if ({bus.div_offset, bus.z_offset, bus.cal_mean} !== {16'h7FFF, 16'h7FFF, 16'h8000}) begin
      miscompares++;
      $display("FAIL sat_pos_values: got %h/%h mean %h want 7fff/7fff mean 8000", bus.div_offset, bus.z_offset, bus.cal_mean);
    end
    vectors++;
    if (bus.saturated !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_pos_flag: got %b want 1", bus.saturated);
    end
    bus.z_trim = 16'h8000;
    start_cal();
    vectors++;
    if (bus.saturated !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_clear_on_start: got %b want 0", bus.saturated);
    end
    feed(16'h0010, NS);
    wait_done(20, got);
    vectors++;
    if ({got, bus.div_offset, bus.z_offset, bus.cal_mean} !== {1'b1, 16'hFFF0, 16'h8000, 16'h0010}) begin
      miscompares++;
      $display("FAIL sat_neg_values: got done=%b %h/%h mean %h want done=1 fff0/8000 mean 0010", got, bus.div_offset, bus.z_offset, bus.cal_mean);
    end
    vectors++;
    if (bus.saturated !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_neg_flag: got %b want 1", bus.saturated);
    end
    bus.z_trim = 16'h0000;
  endtask

  task automatic test_commit_during_accum();
    logic [19:0] prev_mult;
    logic [19:0] mult_before = '0;
    logic [19:0] mult_at = '0;
    bit applied = 1'b0;
    start_cal();
    feed(16'h0020, 2);
    do_commit(10'd50, 10'd60);
    vectors++;
    if ({bus.div_multiplier, bus.z_multiplier} !== {10'd128, 10'd128}) begin
      miscompares++;
      $display("FAIL busy_commit_held1: got %0d/%0d want 128/128", bus.div_multiplier, bus.z_multiplier);
    end
    feed(16'h0020, 2);
    do_commit(10'd70, 10'd80);
    vectors++;
    if ({bus.div_multiplier, bus.z_multiplier} !== {10'd128, 10'd128}) begin
      miscompares++;
      $display("FAIL busy_commit_held2: got %0d/%0d want 128/128", bus.div_multiplier, bus.z_multiplier);
    end
    feed(16'h0020, NS - 4);
    prev_mult = {bus.div_multiplier, bus.z_multiplier};
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!applied && bus.div_offset === 16'hFFE0) begin
        applied = 1'b1;
        mult_before = prev_mult;
        mult_at = {bus.div_multiplier, bus.z_multiplier};
      end
      prev_mult = {bus.div_multiplier, bus.z_multiplier};
      if (bus.done === 1'b1) break;
    end
    vectors++;
    if ({applied, mult_before} !== {1'b1, 10'd128, 10'd128}) begin
      miscompares++;
      $display("FAIL busy_commit_before_apply: got seen=%b %0d/%0d want seen=1 128/128", applied, mult_before[19:10], mult_before[9:0]);
    end
    vectors++;
    if (mult_at !== {10'd70, 10'd80}) begin
      miscompares++;
      $display("FAIL busy_commit_at_apply: got %0d/%0d want 70/80", mult_at[19:10], mult_at[9:0]);
    end
    vectors++;
    if (bus.z_offset !== 16'hFFE0) begin
      miscompares++;
      $display("FAIL busy_commit_z_offset: got %h want ffe0", bus.z_offset);
    end
  endtask

  task automatic test_abort();
    bit got;
    bit done_seen = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    start_cal();
    feed(16'h0100, 5);
    do_commit(10'd90, 10'd91);
    bus.cal_abort = 1'b1;
    tick();
    bus.cal_abort = 1'b0;
    vectors++;
    if ({bus.aborted, bus.busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL abort_pulse: got aborted=%b busy=%b want 1/0", bus.aborted, bus.busy);
    end
    tick();
    vectors++;
    if (bus.aborted !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_pulse_len: got %b want 0", bus.aborted);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.done === 1'b1) done_seen = 1'b1;
    end
    vectors++;
    if ({done_seen, bus.div_offset, bus.z_offset} !== {1'b0, 16'h0000, 16'h0000}) begin
      miscompares++;
      $display("FAIL abort_no_apply: got done=%b %h/%h want done=0 0000/0000", done_seen, bus.div_offset, bus.z_offset);
    end
    start_cal();
    feed(16'h0040, NS);
    wait_done(20, got);
    vectors++;
    if ({got, bus.div_offset, bus.div_multiplier, bus.z_multiplier} !== {1'b1, 16'hFFC0, 10'd128, 10'd128}) begin
      miscompares++;
      $display("FAIL abort_pending_dropped: got done=%b %h %0d/%0d want done=1 ffc0 128/128", got, bus.div_offset, bus.div_multiplier, bus.z_multiplier);
    end
    start_cal();
    feed(16'h0100, NS - 1);
    bus.SUM = 16'h0100;
    bus.sum_valid = 1'b1;
    bus.cal_abort = 1'b1;
    tick();
    bus.sum_valid = 1'b0;
    bus.cal_abort = 1'b0;
    vectors++;
    if (bus.aborted !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_final_sample: got %b want 1", bus.aborted);
    end
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1) done_seen = 1'b1;
    end
    vectors++;
    if ({done_seen, bus.div_offset, bus.cal_mean} !== {1'b0, 16'hFFC0, 16'h0040}) begin
      miscompares++;
      $display("FAIL abort_final_unchanged: got done=%b %h mean %h want done=0 ffc0 mean 0040", done_seen, bus.div_offset, bus.cal_mean);
    end
  endtask

  task automatic test_timeout();
    int cyc = -1;
    start_cal();
    bus.SUM = 16'h0100;
    bus.sum_valid = 1'b1;
    tick();
    bus.sum_valid = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (bus.aborted === 1'b1) begin
        cyc = i;
        break;
      end
    end
    vectors++;
    if (cyc != TMO + 1) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d want %0d", cyc, TMO + 1);
    end
    vectors++;
    if ({bus.busy, bus.done, bus.div_offset, bus.z_offset} !== {2'b00, 16'hFFC0, 16'hFFC0}) begin
      miscompares++;
      $display("FAIL timeout_outputs: got busy=%b done=%b %h/%h want 0/0 ffc0/ffc0", bus.busy, bus.done, bus.div_offset, bus.z_offset);
    end
  endtask

  task automatic test_reset_in_settle();
    bit got;
    bit done_seen = 1'b0;
    do_commit(10'd300, 10'd200);
    start_cal();
    feed(16'h0100, NS);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.div_offset === 16'hFF00) break;
    end
    tick();
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({bus.div_offset, bus.z_offset, bus.cal_mean} !== 48'h0) begin
      miscompares++;
      $display("FAIL settle_reset_offsets: got %h want %h", {bus.div_offset, bus.z_offset, bus.cal_mean}, 48'h0);
    end
    vectors++;
    if ({bus.div_multiplier, bus.z_multiplier, bus.busy, bus.done, bus.aborted, bus.saturated} !== {10'd128, 10'd128, 4'b0000}) begin
      miscompares++;
      $display("FAIL settle_reset_mult_flags: got %0d/%0d flags %b want 128/128 flags 0000", bus.div_multiplier, bus.z_multiplier, {bus.busy, bus.done, bus.aborted, bus.saturated});
    end
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done === 1'b1) done_seen = 1'b1;
    end
    vectors++;
    if (done_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL settle_reset_no_done: got %b want 0", done_seen);
    end
    start_cal();
    feed(16'h0100, NS);
    wait_done(20, got);
    vectors++;
    if ({got, bus.div_offset, bus.z_offset, bus.cal_mean} !== {1'b1, 16'hFF00, 16'hFF00, 16'h0100}) begin
      miscompares++;
      $display("FAIL settle_reset_rerun: got done=%b %h/%h mean %h want done=1 ff00/ff00 mean 0100", got, bus.div_offset, bus.z_offset, bus.cal_mean);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.SUM = '0;
    bus.sum_valid = 1'b0;
    bus.cal_start = 1'b0;
    bus.cal_abort = 1'b0;
    bus.z_trim = '0;
    bus.staged_div_multiplier = '0;
    bus.staged_z_multiplier = '0;
    bus.commit = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_basic();
    test_idle_commit();
    test_saturation();
    test_commit_during_accum();
    test_abort();
    test_timeout();
    test_reset_in_settle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sum_offset_calibrator.md
Name: sum_offset_calibrator

Overview:
Configuration controller for the SUM offset/scale datapath, which adds offsets to SUM and then multiplies it to produce sumForDivision and z.
- Drives the four coefficient inputs of that datapath: div_offset, div_multiplier, z_offset and z_multiplier.
- On request, averages 2^LOG2_SAMPLES raw SUM samples and sets both offsets to the negated mean, so SUM is nulled; z also gets a host trim.
- Host-staged multipliers are applied atomically with the offsets, so the datapath never sees a half-updated coefficient set.

Parameters:
INPUT_BIT_SIZE, 16, width of SUM and of the offsets; signed two's complement.
COEFF_BIT_SIZE, 10, width of the multipliers.
LOG2_SAMPLES, 10, log2 of the number of samples averaged per calibration.
SETTLE_CYCLES, 4, wait after applying coefficients before done; must be ≥ the datapath latency of 2.
TIMEOUT_CYCLES, 65535, maximum number of cycles allowed between sum_valid pulses during accumulation.
DEFAULT_MULTIPLIER, 128, reset value of both multipliers; 1.0 with 7 fractional bits.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
SUM  in  INPUT_BIT_SIZE  raw signed SUM sample
sum_valid  in  1  SUM qualifier, one-cycle pulse per sample
cal_start  in  1  pulse: begin a calibration
cal_abort  in  1  pulse: cancel the calibration in progress
z_trim  in  INPUT_BIT_SIZE  signed trim added to the z offset
staged_div_multiplier  in  COEFF_BIT_SIZE  host-staged div multiplier
staged_z_multiplier  in  COEFF_BIT_SIZE  host-staged z multiplier
commit  in  1  pulse: apply the staged multipliers
div_offset  out  INPUT_BIT_SIZE  active div offset
z_offset  out  INPUT_BIT_SIZE  active z offset
div_multiplier  out  COEFF_BIT_SIZE  active div multiplier
z_multiplier  out  COEFF_BIT_SIZE  active z multiplier
cal_mean  out  INPUT_BIT_SIZE  last measured mean
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse when a calibration completes
aborted  out  1  one-cycle pulse on abort or timeout
saturated  out  1  sticky flag, cleared by cal_start

Behaviour:
Reset (asynchronous, active-low), with every output forced as listed:
- offsets = 0, multipliers = DEFAULT_MULTIPLIER, cal_mean = 0.
- busy, done, aborted, saturated = 0.
- state = IDLE, pending commit cleared.
- Reset asserted mid-calibration discards everything.

IDLE:
- cal_start → ACCUM; clears the accumulator, sample counter, timeout counter and saturated.
- commit → both multipliers load from the staged inputs on the next edge. Offsets are untouched.

ACCUM:
- Each sum_valid adds sign-extended SUM into an accumulator of INPUT_BIT_SIZE+LOG2_SAMPLES bits. This width cannot overflow.
- The sample counter increments per valid. When 2^LOG2_SAMPLES samples are accepted → COMPUTE.
- The timeout counter resets on each sum_valid. Reaching TIMEOUT_CYCLES → IDLE with an aborted pulse; outputs are unchanged.

COMPUTE (1 cycle):
- mean = accumulator arithmetically shifted right by LOG2_SAMPLES (floor); register it into cal_mean.
- d = -mean.
- zo = d + z_trim, computed at full width.
- Each result saturates to the signed INPUT_BIT_SIZE range. Any saturation sets saturated.

APPLY (1 cycle):
- div_offset ← d and z_offset ← zo on the same edge.
- If a commit is pending, both multipliers load on that same edge and the pending flag clears.

SETTLE:
- Counts SETTLE_CYCLES, then → IDLE with a done pulse. busy falls on the same edge.

Commit while busy:
- Latched as pending, with the staged values sampled at commit time.
- Applied in APPLY.
- A later commit overwrites an earlier one.
- An abort or timeout discards it.

Other rules:
- cal_start while busy is ignored.
- cal_abort in IDLE is ignored.
- cal_abort in ACCUM, COMPUTE, APPLY or SETTLE → IDLE with an aborted pulse. In ACCUM and COMPUTE nothing is applied. In APPLY and SETTLE the new coefficients have already been written and remain in effect.
- cal_abort has priority over sum_valid in the same cycle. A sample arriving on the final-count cycle together with abort is dropped.
- The outputs are registers: there is no combinational path from any input.

Decomposition:
- Shared package holds:
  - state enum IDLE/ACCUM/COMPUTE/APPLY/SETTLE;
  - an ACC_W function (INPUT_BIT_SIZE+LOG2_SAMPLES);
  - a saturate-to-signed-width function, also reused by the datapath adders.
- One sub-module, sample_averager:
  - inputs: clear, valid, SUM;
  - contains the accumulator, sample counter and timeout counter;
  - outputs: full, timeout, mean.
- The FSM, coefficient registers and commit logic stay in the top.

Test Plan:
- LOG2_SAMPLES=4, SUM=16'h0100 constant, valid every 3rd cycle, z_trim=0 → div_offset=z_offset=16'hFF00, cal_mean=16'h0100, done exactly SETTLE_CYCLES+1 cycles after the APPLY edge.
- SUM=16'h8000 constant → div_offset=16'h7FFF and saturated=1. Then SUM=16'h0010 with z_trim=16'h8000 → div_offset=16'hFFF0, z_offset=16'h8000 (saturated), flag set.
- IDLE, staged multipliers 200/300, commit → multipliers read 200/300 the following cycle; offsets unchanged.
- Commit 50/60 during ACCUM, then 70/80 → multipliers stay 128 until the APPLY edge, then read 70/80 on the same edge the offsets update.
- cal_abort after 5 of 16 samples → aborted pulse, offsets remain 0, a pending commit is discarded, done never asserts. Separately, stop sum_valid → timeout abort after TIMEOUT_CYCLES.
- Reset asserted in SETTLE → all outputs at reset values immediately, with no done; the next cal_start runs a full calibration.
